// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each rising edge on event_in becomes one HOLD_CYCLES-wide pulse,
// followed by at least GAP_CYCLES low cycles; extra events queue in a saturating counter.
//
// state | meaning
// IDLE  | output low, waiting for an edge or a queued event
// HOLD  | output high, counting HOLD_CYCLES
// GAP   | output low, counting GAP_CYCLES before the next pulse may start
module pulse_stretcher #(
    parameter logic [15:0] HOLD_CYCLES = 16'd1000,
    parameter logic [15:0] GAP_CYCLES  = 16'd1000,
    parameter logic [2:0]  PEND_MAX    = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       event_in,
    input  logic       clear_ovf,
    output logic       stretched,
    output logic       busy,
    output logic [2:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stretched_q, stretched_d;
    logic [2:0]  pending_q, pending_d;
    logic        overflow_q, overflow_d;
    logic        event_q;
    logic        evt_edge;
    logic        ovf_set;

    assign evt_edge = event_in & ~event_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            stretched_q <= 1'b0;
            pending_q   <= 3'd0;
            overflow_q  <= 1'b0;
            // A level already high at reset release must not count as an event
            event_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stretched_q <= stretched_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            event_q     <= event_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        stretched_d = stretched_q;
        pending_d   = pending_q;
        ovf_set     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d       = 16'd0;
                stretched_d = 1'b0;
                if (evt_edge || (pending_q != 3'd0)) begin
                    state_d     = HOLD;
                    stretched_d = 1'b1;
                    // A simultaneous edge replaces the consumed queued event
                    if (!evt_edge) begin
                        pending_d = pending_q - 3'd1;
                    end
                end
            end
            HOLD: begin
                stretched_d = 1'b1;
                if (cnt_q == HOLD_CYCLES - 16'd1) begin
                    state_d     = GAP;
                    cnt_d       = 16'd0;
                    stretched_d = 1'b0;
                end
            end
            GAP: begin
                stretched_d = 1'b0;
                if (cnt_q == GAP_CYCLES - 16'd1) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = 16'd0;
                stretched_d = 1'b0;
            end
        endcase

        if ((state_q != IDLE) && evt_edge) begin
            if (pending_q < PEND_MAX) begin
                pending_d = pending_q + 3'd1;
            end else begin
                ovf_set = 1'b1;
            end
        end

        overflow_d = ovf_set | (overflow_q & ~clear_ovf);
    end

    assign stretched = stretched_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) || (pending_q != 3'd0);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD=4, GAP=3, PEND_MAX=2:
// a vector table for the single/queued pulse sequences plus hand-written corner cases.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       event_in;
    logic       clear_ovf;
    logic       stretched;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .HOLD_CYCLES(16'd4),
        .GAP_CYCLES (16'd3),
        .PEND_MAX   (3'd2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .clear_ovf(clear_ovf),
        .stretched(stretched),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    typedef struct {
        logic       ev;
        logic       clr;
        logic       exp_st;
        logic       exp_busy;
        logic [2:0] exp_p;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ev, input logic clr, input logic st,
                       input logic bsy, input logic [2:0] p, input logic ovf);
        vec_t v;
        v.ev = ev; v.clr = clr; v.exp_st = st; v.exp_busy = bsy; v.exp_p = p; v.exp_ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input string name, input logic st, input logic bsy,
                             input logic [2:0] p, input logic ovf);
        check({name, ".stretched"}, int'(stretched), int'(st));
        check({name, ".busy"},      int'(busy),      int'(bsy));
        check({name, ".pending"},   int'(pending),   int'(p));
        check({name, ".overflow"},  int'(overflow),  int'(ovf));
    endtask

    // Inputs are driven 1 time unit after a posedge; outputs sampled 1 unit after the next.
    task automatic step(input logic ev, input logic clr);
        event_in  = ev;
        clear_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        event_in  = 1'b0;
        clear_ovf = 1'b0;
        while (busy && n < 60) begin
            step(1'b0, 1'b0);
            n++;
        end
        check({name, ".idle_timeout"}, int'(busy), 0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        int highs;
        int lows;

        rst       = 1'b1;
        event_in  = 1'b0;
        clear_ovf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // ev clr | st busy pending ovf
        add(0,0, 0,0,0,0);            // event_q settles low after reset
        // single 1-cycle event
        add(1,0, 1,1,0,0);
        add(0,0, 1,1,0,0);
        add(0,0, 1,1,0,0);
        add(0,0, 1,1,0,0);
        add(0,0, 0,1,0,0);
        add(0,0, 0,1,0,0);
        add(0,0, 0,1,0,0);
        add(0,0, 0,0,0,0);
        add(0,0, 0,0,0,0);
        // first pulse plus three events while busy, third overflows
        add(1,0, 1,1,0,0);
        add(0,0, 1,1,0,0);
        add(1,0, 1,1,1,0);
        add(0,0, 1,1,1,0);
        add(1,0, 0,1,2,0);
        add(0,0, 0,1,2,0);
        add(1,0, 0,1,2,1);
        add(0,0, 0,1,2,1);
        add(0,0, 1,1,1,1);            // queued pulse 2
        add(0,0, 1,1,1,1);
        add(0,0, 1,1,1,1);
        add(0,0, 1,1,1,1);
        add(0,0, 0,1,1,1);
        add(0,0, 0,1,1,1);
        add(0,0, 0,1,1,1);
        add(0,0, 0,1,1,1);
        add(0,0, 1,1,0,1);            // queued pulse 3
        add(0,0, 1,1,0,1);
        add(0,0, 1,1,0,1);
        add(0,0, 1,1,0,1);
        add(0,0, 0,1,0,1);
        add(0,0, 0,1,0,1);
        add(0,0, 0,1,0,1);
        add(0,0, 0,0,0,1);
        add(0,1, 0,0,0,0);            // clear_ovf alone

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ev, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_busy,
                      vecs[i].exp_p, vecs[i].exp_ovf);
        end

        // event_in held high for 20 cycles -> one 4-cycle pulse
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (stretched) highs++;
        end
        check("held.high_cycles", highs, 4);
        check("held.pending", int'(pending), 0);
        check("held.overflow", int'(overflow), 0);
        wait_idle("held");

        // clear_ovf coincident with saturating event: set wins
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("sat.pending", int'(pending), 2);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("sat.set_wins", int'(overflow), 1);
        step(1'b0, 1'b1);
        check("sat.cleared", int'(overflow), 0);
        wait_idle("sat");
        check("sat.final_pending", int'(pending), 0);

        // edge on the final GAP cycle
        step(1'b1, 1'b0);                          // HOLD
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        lows = 0;
        for (int i = 0; i < 3; i++) begin          // -> GAP, cnt 0..2
            step(1'b0, 1'b0);
            if (!stretched) lows++;
        end
        step(1'b1, 1'b0);                          // final GAP cycle
        if (!stretched) lows++;
        check("lastgap.pending", int'(pending), 1);
        check("lastgap.busy", int'(busy), 1);
        step(1'b0, 1'b0);
        check("lastgap.restart", int'(stretched), 1);
        check("lastgap.pending_dec", int'(pending), 0);
        check("lastgap.low_cycles", lows, 4);
        wait_idle("lastgap");

        // reset mid-HOLD with pending=1 and event_in held high through release
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("rst.pre_pending", int'(pending), 1);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        check_all("rst.after", 1'b0, 1'b0, 3'd0, 1'b0);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            if (stretched || busy) highs++;
        end
        check("rst.no_pulse", highs, 0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("rst.new_edge", int'(stretched), 1);
        wait_idle("rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the input debouncer. The debouncer removes short pulses; this block lengthens them.
- Turns single-cycle or short events into output pulses that are visible and well separated, e.g. for LEDs, status lines or external strobes.
- Each rising edge on the event input produces exactly one output pulse, held high for HOLD_CYCLES clocks.
- A low gap of at least GAP_CYCLES clocks is enforced between pulses.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter.

Parameters:
- HOLD_CYCLES, 16'd1000, number of cycles stretched stays high per event; must be >= 1.
- GAP_CYCLES, 16'd1000, minimum number of low cycles after each pulse; must be >= 1.
- PEND_MAX, 3'd7, saturation value of the pending-event counter; range 1..7.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- event_in  input  1  event level; each 0->1 transition sampled at posedge is one event.
- clear_ovf  input  1  single-cycle request to clear overflow.
- stretched  output  1  registered stretched pulse output.
- busy  output  1  high when state != IDLE or pending != 0.
- pending  output  3  number of queued events not yet emitted.
- overflow  output  1  sticky flag: an event was dropped at saturation.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values on the posedge with rst=1:
  - state=IDLE, stretched=0, pending=0, overflow=0, cycle counter=0.
  - event_q=1, so an input already high when reset releases does not count as an event.
- Edge detect: edge = event_in & ~event_q, where event_q is event_in registered every cycle.
- States (2-bit): IDLE, HOLD, GAP. A 16-bit counter is cleared on every state entry.
- IDLE:
  - On edge, or when pending != 0: next state HOLD, stretched<=1.
  - If this start was caused by pending (no edge that cycle), pending decrements by 1.
  - If edge and pending != 0 occur together: start HOLD, pending unchanged (edge queued, one consumed).
  - Otherwise stay in IDLE with stretched=0.
- HOLD:
  - stretched=1, counter increments each cycle.
  - When counter == HOLD_CYCLES-1: go to GAP, stretched<=0.
  - stretched is therefore high for exactly HOLD_CYCLES cycles.
- GAP:
  - stretched=0, counter increments each cycle.
  - When counter == GAP_CYCLES-1: go to IDLE.
  - Back-to-back queued pulses are therefore separated by GAP_CYCLES+1 low cycles.
- Events while in HOLD or GAP:
  - If pending < PEND_MAX, pending increments.
  - If pending == PEND_MAX, pending stays put and overflow<=1.
- Latency: stretched rises on the same posedge that samples the edge, i.e. one clock after event_in rises.
- Event_in held high indefinitely produces exactly one event.
- overflow:
  - Cleared by clear_ovf.
  - If clear_ovf and a new overflow occur in the same cycle, overflow is 1 (set wins).
- Reset mid-operation: all state and outputs return to reset values on that posedge. Queued events are discarded.
- No combinational path from event_in to stretched.
- busy is derived combinationally from the registered state and pending only.

Test Plan:
Parameters for all cases: HOLD_CYCLES=4, GAP_CYCLES=3, PEND_MAX=2.
1. 1-cycle pulse on event_in at cycle T -> stretched=1 for cycles T+1..T+4, 0 from T+5. busy high T+1..T+7, low at T+8. pending stays 0.
2. event_in held high for 20 cycles -> exactly one 4-cycle stretched pulse, pending=0, overflow=0.
3. Three 1-cycle pulses separated by idle cycles during the first HOLD -> pending goes 1, 2, 2 and overflow=1 on the third. Output is 3 pulses of 4 cycles each (first + 2 queued), each separated by 4 low cycles. Final pending=0, busy=0.
4. rst asserted 1 cycle mid-HOLD with pending=1 and event_in held high through reset release -> stretched=0, pending=0, overflow=0 next cycle. No further pulse until event_in falls and rises again.
5. clear_ovf asserted in the same cycle as a saturating event -> overflow remains 1. clear_ovf alone on a later cycle -> overflow=0 on the next cycle.
6. Edge on the final GAP cycle -> pending=1, then IDLE one cycle, then HOLD with pending decremented to 0. The low gap between pulses is 4 cycles.
